// File: rtl/my_exec_stage_if.sv
// Bus bundle for my_exec_stage: instruction handshake, ALU operand/result
// bus, memory read/write bus, jump result and architectural registers.
// master = the execute stage, slave = its environment.
interface my_exec_stage_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx;
    logic        alu_nx;
    logic        alu_zy;
    logic        alu_ny;
    logic        alu_f;
    logic        alu_no;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;

    logic [14:0] mem_addr;
    logic        mem_rd;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        mem_wr;
    logic [15:0] mem_wdata;

    logic        jump_valid;
    logic        jump_taken;
    logic [14:0] jump_target;

    logic [15:0] a_reg;
    logic [15:0] d_reg;

    modport master (
        input  instr, instr_valid, alu_out, alu_zr, alu_ng, mem_rvalid, mem_rdata,
        output instr_ready, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
               mem_addr, mem_rd, mem_wr, mem_wdata, jump_valid, jump_taken, jump_target,
               a_reg, d_reg
    );

    modport slave (
        output instr, instr_valid, alu_out, alu_zr, alu_ng, mem_rvalid, mem_rdata,
        input  instr_ready, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
               mem_addr, mem_rd, mem_wr, mem_wdata, jump_valid, jump_taken, jump_target,
               a_reg, d_reg
    );
endinterface

// File: rtl/my_exec_stage.sv
// Execute/writeback stage for the 16-bit Hack-style datapath.
// Owns A and D, drives the external combinational ALU, fetches M when the
// a-bit is set, writes back A/D/M and evaluates the jump condition.
// Optional feature macro: MY_EXEC_JUMP_EN (jump evaluation; when undefined
// all jump outputs are tied to 0).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for an instruction; A-instructions complete here
// S_MEMRD | C-instruction with a=1, waiting for mem_rvalid to capture M
// S_EXEC  | one cycle: ALU driven, destination writes and jump evaluated
module my_exec_stage #(
    parameter logic [15:0] RESET_A = 16'h0000,
    parameter logic [15:0] RESET_D = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    my_exec_stage_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MEMRD = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_a_bit;
    logic [5:0]  r_comp;
    logic [2:0]  r_dest;
    logic [15:0] r_m;
    logic [15:0] r_a;
    logic [15:0] r_d;
    logic [15:0] r_alu_x;
    logic [15:0] r_alu_y;

    logic        w_ready;
    logic        w_mem_rd;
    logic        w_exec;
    logic        w_exec_act;
    logic        w_accept;
    logic [15:0] w_exec_y;

    // A reset cycle must never produce a write, read or jump strobe
    assign w_exec_act = w_exec & ~reset;
    assign w_accept   = (r_state == S_IDLE) & bus.instr_valid;
    assign w_exec_y   = r_a_bit ? r_m : r_a;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_mem_rd = 1'b0;
        w_exec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid && bus.instr[15]) begin
                    w_next = bus.instr[12] ? S_MEMRD : S_EXEC;
                end
            end
            S_MEMRD: begin
                w_mem_rd = 1'b1;
                if (bus.mem_rvalid) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: instruction latch, M capture, A/D writeback, operand hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= RESET_A;
            r_d     <= RESET_D;
            r_a_bit <= 1'b0;
            r_comp  <= 6'd0;
            r_dest  <= 3'd0;
            r_m     <= 16'd0;
            r_alu_x <= 16'd0;
            r_alu_y <= 16'd0;
        end else begin
            if (w_accept) begin
                if (!bus.instr[15]) begin
                    r_a <= {1'b0, bus.instr[14:0]};
                end else begin
                    r_a_bit <= bus.instr[12];
                    r_comp  <= bus.instr[11:6];
                    r_dest  <= bus.instr[5:3];
                end
            end
            if ((r_state == S_MEMRD) && bus.mem_rvalid) begin
                r_m <= bus.mem_rdata;
            end
            if (w_exec) begin
                r_alu_x <= r_d;
                r_alu_y <= w_exec_y;
                if (r_dest[2]) r_a <= bus.alu_out;
                if (r_dest[1]) r_d <= bus.alu_out;
            end
        end
    end

    assign bus.instr_ready = w_ready & ~reset;

    // Operands follow the live registers in EXEC and freeze afterwards
    assign bus.alu_x  = w_exec ? r_d      : r_alu_x;
    assign bus.alu_y  = w_exec ? w_exec_y : r_alu_y;
    assign bus.alu_zx = w_exec_act & r_comp[5];
    assign bus.alu_nx = w_exec_act & r_comp[4];
    assign bus.alu_zy = w_exec_act & r_comp[3];
    assign bus.alu_ny = w_exec_act & r_comp[2];
    assign bus.alu_f  = w_exec_act & r_comp[1];
    assign bus.alu_no = w_exec_act & r_comp[0];

    // r_a still holds the pre-instruction A during EXEC, so dA+dM writes old address
    assign bus.mem_addr  = r_a[14:0];
    assign bus.mem_rd    = w_mem_rd & ~reset;
    assign bus.mem_wr    = w_exec_act & r_dest[0];
    assign bus.mem_wdata = bus.alu_out;

    assign bus.a_reg = r_a;
    assign bus.d_reg = r_d;

`ifdef MY_EXEC_JUMP_EN
    logic [2:0] r_jmp;
    logic       w_cond;

    // Jump condition bits captured with the C-instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_jmp <= 3'd0;
        end else if (w_accept && bus.instr[15]) begin
            r_jmp <= bus.instr[2:0];
        end
    end

    assign w_cond = (r_jmp[2] & bus.alu_ng) |
                    (r_jmp[1] & bus.alu_zr) |
                    (r_jmp[0] & ~bus.alu_ng & ~bus.alu_zr);

    assign bus.jump_valid  = w_exec_act;
    assign bus.jump_taken  = w_exec_act & w_cond;
    assign bus.jump_target = w_exec_act ? r_a[14:0] : 15'd0;
`else
    assign bus.jump_valid  = 1'b0;
    assign bus.jump_taken  = 1'b0;
    assign bus.jump_target = 15'd0;
`endif

endmodule

// File: tb/tb_my_exec_stage.sv
// Directed bench for my_exec_stage with a reference Hack ALU and a
// scoreboard for memory-write and jump events.
module tb_my_exec_stage;

    localparam logic [15:0] RA = 16'h1234;
    localparam logic [15:0] RD = 16'h00AB;
`ifdef MY_EXEC_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    my_exec_stage_if bus ();

    my_exec_stage #(.RESET_A(RA), .RESET_D(RD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Hack ALU
    logic [15:0] x1, x2, y1, y2, ao;
    always_comb begin
        x1 = bus.alu_zx ? 16'd0 : bus.alu_x;
        x2 = bus.alu_nx ? ~x1 : x1;
        y1 = bus.alu_zy ? 16'd0 : bus.alu_y;
        y2 = bus.alu_ny ? ~y1 : y1;
        ao = bus.alu_f ? (x2 + y2) : (x2 & y2);
        ao = bus.alu_no ? ~ao : ao;
    end
    assign bus.alu_out = ao;
    assign bus.alu_zr  = (ao == 16'd0);
    assign bus.alu_ng  = ao[15];

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } mem_exp_t;
    typedef struct {
        logic        taken;
        logic [14:0] target;
    } jmp_exp_t;

    mem_exp_t exp_mem[$];
    jmp_exp_t exp_jmp[$];
    mem_exp_t me;
    jmp_exp_t je;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] w);
        @(negedge clk);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        #1;
        chk("ready_at_issue", bus.instr_ready, 1);
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
    endtask

    function automatic logic [5:0] ctrl();
        return {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no};
    endfunction

    // Scoreboard: each strobe cycle consumes exactly one expected event
    always @(negedge clk) begin
        #1;
        if (bus.mem_wr === 1'b1) begin
            if (exp_mem.size() == 0) begin
                chk("mem_wr_unexpected", bus.mem_wr, 0);
            end else begin
                me = exp_mem.pop_front();
                chk("mem_waddr", bus.mem_addr, me.addr);
                chk("mem_wdata", bus.mem_wdata, me.data);
            end
        end
        if (bus.jump_valid === 1'b1) begin
            if (exp_jmp.size() == 0) begin
                chk("jump_unexpected", bus.jump_valid, 0);
            end else begin
                je = exp_jmp.pop_front();
                chk("jump_taken", bus.jump_taken, je.taken);
                chk("jump_target", bus.jump_target, je.target);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.instr = 16'd0;
        bus.instr_valid = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_a", bus.a_reg, RA);
        chk("rst_d", bus.d_reg, RD);
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_strobes", {bus.mem_rd, bus.mem_wr, bus.jump_valid, bus.jump_taken}, 0);
        chk("rst_ctrl", ctrl(), 0);
        chk("rst_target", bus.jump_target, 0);

        // back-to-back A-instructions
        issue(16'h0005);
        issue(16'h7FFF);
        chk("a_first", bus.a_reg, 16'h0005);
        idle_cyc();
        chk("a_second", bus.a_reg, 16'h7FFF);
        chk("a_ready", bus.instr_ready, 1);

        // D=A
        issue(16'h0003);
        issue(16'hEC10);
        chk("ctrl_idle", ctrl(), 0);
        idle_cyc();
        chk("exec_ctrl", ctrl(), 6'b110000);
        chk("exec_x", bus.alu_x, RD);
        chk("exec_y", bus.alu_y, 16'h0003);
        chk("exec_ready", bus.instr_ready, 0);
        idle_cyc();
        chk("d_eq_a", bus.d_reg, 16'h0003);
        chk("ctrl_after", ctrl(), 0);
        chk("x_hold", bus.alu_x, RD);
        chk("y_hold", bus.alu_y, 16'h0003);

        // AM=D+1 with A=100, D=7: write to old A
        issue(16'h0007);
        issue(16'hEC10);
        idle_cyc();
        idle_cyc();
        chk("d_seven", bus.d_reg, 16'h0007);
        issue(16'd100);
        exp_mem.push_back('{addr: 15'd100, data: 16'd8});
        issue(16'hE7E8);
        idle_cyc();
        chk("am_wr", bus.mem_wr, 1);
        idle_cyc();
        chk("am_wr_off", bus.mem_wr, 0);
        chk("am_a", bus.a_reg, 16'd8);
        chk("am_d", bus.d_reg, 16'd7);

        // D=M with 3 wait cycles; stray rvalid and instr_valid ignored
        @(negedge clk);
        bus.instr = 16'd20;
        bus.instr_valid = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'h0BAD;
        @(negedge clk);
        bus.instr = 16'hFC10;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.instr = 16'h0001;
            bus.instr_valid = 1'b1;
            bus.mem_rvalid = (i == 3);
            bus.mem_rdata = (i == 3) ? 16'hFFFF : 16'h1234;
            #1;
            chk("mrd_rd", bus.mem_rd, 1);
            chk("mrd_addr", bus.mem_addr, 15'd20);
            chk("mrd_ready", bus.instr_ready, 0);
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.mem_rvalid = 1'b0;
        #1;
        chk("mrd_exec_rd", bus.mem_rd, 0);
        chk("mrd_exec_y", bus.alu_y, 16'hFFFF);
        chk("mrd_exec_x", bus.alu_x, 16'd7);
        idle_cyc();
        chk("mrd_d", bus.d_reg, 16'hFFFF);
        chk("mrd_a", bus.a_reg, 16'd20);

        // D=D-1, then jumps on D=FFFE with A=42
        issue(16'hE390);
        idle_cyc();
        idle_cyc();
        chk("d_fffe", bus.d_reg, 16'hFFFE);
        issue(16'd42);
        if (JEN) exp_jmp.push_back('{taken: 1'b1, target: 15'd42});
        issue(16'hE304);
        idle_cyc();
        chk("jlt_valid", bus.jump_valid, JEN);
        chk("jlt_taken", bus.jump_taken, JEN);
        chk("jlt_target", bus.jump_target, JEN ? 15'd42 : 15'd0);
        idle_cyc();
        chk("jmp_off", {bus.jump_valid, bus.jump_taken}, 0);
        if (JEN) exp_jmp.push_back('{taken: 1'b0, target: 15'd42});
        issue(16'hE301);
        idle_cyc();
        chk("jgt_valid", bus.jump_valid, JEN);
        chk("jgt_taken", bus.jump_taken, 0);
        idle_cyc();
        chk("jmp_d", bus.d_reg, 16'hFFFE);
        chk("jmp_a", bus.a_reg, 16'd42);

        // reset during MEMRD
        issue(16'hFC38);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        reset = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'h5555;
        @(negedge clk);
        reset = 1'b0;
        bus.mem_rvalid = 1'b0;
        #1;
        chk("rmrd_ready", bus.instr_ready, 1);
        chk("rmrd_a", bus.a_reg, RA);
        chk("rmrd_d", bus.d_reg, RD);
        chk("rmrd_rd", bus.mem_rd, 0);
        idle_cyc();
        chk("rmrd_idle", {bus.instr_ready, bus.mem_rd, bus.mem_wr}, 3'b100);

        // reset during EXEC of a write instruction
        issue(16'd9);
        issue(16'hE7E8);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rexec_wr", bus.mem_wr, 0);
        chk("rexec_ctrl", ctrl(), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rexec_a", bus.a_reg, RA);
        chk("rexec_d", bus.d_reg, RD);
        chk("rexec_ready", bus.instr_ready, 1);

        idle_cyc();
        chk("sb_mem_empty", exp_mem.size(), 0);
        chk("sb_jmp_empty", exp_jmp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/my_exec_stage.md
# my_exec_stage

Execute/writeback stage for the 16-bit Hack-style datapath. Accepts one instruction at a time over a valid/ready handshake and owns the A and D registers. Drives the combinational `my_alu` with operands and the six control bits, then consumes `alu_out`/`alu_zr`/`alu_ng` to write back A, D and memory and to evaluate the jump condition. Fetches the M operand through a simple read handshake when the instruction's a-bit is set.

## Interface
- `RESET_A`, default 16'h0000: A register reset value.
- `RESET_D`, default 16'h0000: D register reset value.
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: synchronous, active-high.
- `instr`  in  16: instruction word. Bit 15=0 is an A-instruction; otherwise [12]=a, [11:6]=zx,nx,zy,ny,f,no, [5:3]=dA,dD,dM, [2:0]=j_lt,j_eq,j_gt.
- `instr_valid` / `instr_ready`  in / out  1: instruction handshake.
- `alu_x`, `alu_y`  out  16: ALU operands (x=D, y=A or M).
- `alu_zx`, `alu_nx`, `alu_zy`, `alu_ny`, `alu_f`, `alu_no`  out  1 each: ALU controls.
- `alu_out`  in  16; `alu_zr`, `alu_ng`  in  1: ALU results, combinational from the above.
- `mem_addr`  out  15: A[14:0] for reads and writes.
- `mem_rd`  out  1; `mem_rvalid`  in  1; `mem_rdata`  in  16: M read handshake.
- `mem_wr`  out  1; `mem_wdata`  out  16: single-cycle write strobe.
- `jump_valid`, `jump_taken`  out  1; `jump_target`  out  15: jump result.
- `a_reg`, `d_reg`  out  16: architectural registers.

## Operation
- States: IDLE, MEMRD, EXEC. `instr_ready` = (state==IDLE).
- IDLE with A-instruction handshake: `a_reg` <= {1'b0, instr[14:0]}. Remain in IDLE. No ALU, memory or jump activity.
- IDLE with C-instruction handshake: latch instr. If a=1, go to MEMRD; otherwise go to EXEC.
- MEMRD: `mem_rd`=1 and `mem_addr`=A[14:0]. On `mem_rvalid`, latch `mem_rdata` as M and go to EXEC. There is no timeout; the stage waits indefinitely.
- EXEC (exactly one cycle):
  - `alu_x`=D; `alu_y`=M if a=1, else A.
  - Control bits come from the latched instr.
  - At the clock edge, apply the destination writes in parallel, all using the pre-instruction A:
    - dA: A <= alu_out.
    - dD: D <= alu_out.
    - dM: `mem_wr`=1, `mem_wdata`=alu_out, `mem_addr`=old A[14:0].
  - `jump_valid`=1. `jump_taken` = (j_lt&ng)|(j_eq&zr)|(j_gt&!ng&!zr). `jump_target` = old A[14:0].
  - Next state is IDLE.
- Outside EXEC: ALU controls are 0 and `alu_x`/`alu_y` hold their last values. `mem_wr`, `jump_valid` and `jump_taken` are 0.
- All arithmetic is 16-bit two's complement inside the ALU. This block does no arithmetic itself.

## Timing
- Reset values: state IDLE, `a_reg`=RESET_A, `d_reg`=RESET_D. All strobes (`mem_rd`, `mem_wr`, `jump_valid`, `jump_taken`) and ALU controls are 0. `jump_target`=0. `instr_ready`=1 from the first cycle after reset deasserts.
- Latency:
  - A-instruction: 1 cycle, back-to-back at full rate.
  - C-instruction with a=0: 2 cycles (IDLE, EXEC).
  - C-instruction with a=1: 2 + N cycles, where N≥1 is the number of MEMRD cycles up to and including the cycle with `mem_rvalid`.
- Register writes are visible on `a_reg`/`d_reg` the cycle after EXEC.
- `mem_wr`, `jump_valid` and `jump_taken` are combinational in EXEC only, so each pulses exactly 1 cycle.
- `mem_rvalid` outside MEMRD is ignored. `instr_valid` outside IDLE is ignored, with no stall corruption.
- Reset mid-operation (MEMRD or EXEC): that cycle produces no register, memory or jump update. The pending instruction is dropped and the state returns to IDLE.
- dA and dM together: the write goes to the old A address; A updates after.

## Configuration
- `MY_EXEC_JUMP_EN` defined: jump evaluation as specified.
- Not defined: `jump_valid`, `jump_taken` and `jump_target` are tied to 0, the j bits are ignored, and the jump-condition logic is not synthesized. All other behaviour is identical.

## Test plan
- Reset, then A-instr 16'h0005 then 16'h7FFF on consecutive cycles -> `a_reg`=5 then 16'h7FFF; `instr_ready` stays 1.
- A=3, then C-instr D=A (comp 110000, dD) -> after 2 cycles `d_reg`=3; ALU controls pulse zx=1,nx=1,zy=0,ny=0,f=0,no=0 in EXEC only.
- A=100, D=7, C-instr M=D+1 with dA,dM (comp 011111) -> `mem_wr` pulse with addr 100, data 8; then `a_reg`=8.
- A=20, C-instr D=M (a=1), `mem_rvalid` held off 3 cycles with rdata 16'hFFFF -> `mem_rd` high 4 cycles, `d_reg`=16'hFFFF, total latency 6 cycles.
- D=16'hFFFE, A=42, C-instr D;JLT -> `jump_valid`=1, `jump_taken`=1, target 42. Same with JGT -> taken=0. With macro undefined -> all jump outputs 0.
- Assert reset during MEMRD -> no `mem_wr`, no register change, state IDLE, `instr_ready`=1 after reset.
